// File: rtl/purchase_pkg.sv
// -----------------------------------------------------------------------------
// purchase_pkg
// Shared definitions for the purchase engine:
//   state_t          controller state encoding
//   ERR_*            error codes reported on err_code
//   LOG_SOLD/REJECT  log operator constants for purchase records (log_status)
// -----------------------------------------------------------------------------
package purchase_pkg;

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOOKUP,
      S_CHECK,
      S_DIV,
      S_DEBIT,
      S_CREDIT,
      S_STOCK,
      S_LOG,
      S_RESP
   } state_t;

   localparam logic [2:0] ERR_OK               = 3'd0;
   localparam logic [2:0] ERR_BAD_CODE         = 3'd1;
   localparam logic [2:0] ERR_ZERO_COUNT       = 3'd2;
   localparam logic [2:0] ERR_NO_FUNDS_ANY     = 3'd3;
   localparam logic [2:0] ERR_NO_FUNDS_PARTIAL = 3'd4;
   localparam logic [2:0] ERR_NO_STOCK         = 3'd5;

   // Log operator: status bit written with every purchase record.
   localparam logic LOG_SOLD     = 1'b1;
   localparam logic LOG_REJECTED = 1'b0;

endpackage

// File: rtl/purchase_divider.sv
// -----------------------------------------------------------------------------
// purchase_divider
// Restoring divider, one quotient bit per clock, MONEY_W iterations.
//   clock, reset  rising-edge clock, synchronous active-high reset
//   start         begin a division (taken only while ready)
//   dividend      MONEY_W-bit dividend, sampled with start
//   divisor       PRICE_W-bit divisor, sampled with start
//   ready         idle and able to take start (low during and on the done cycle)
//   done          one-cycle pulse exactly MONEY_W cycles after start is taken
//   quotient      floor(dividend/divisor), valid while done (held afterwards)
// A zero divisor yields an all-ones quotient.
// -----------------------------------------------------------------------------
module purchase_divider #(
   parameter int MONEY_W = 8,
   parameter int PRICE_W = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [MONEY_W-1:0] dividend,
   input  logic [PRICE_W-1:0] divisor,
   output logic               ready,
   output logic               done,
   output logic [MONEY_W-1:0] quotient
);

   localparam int STEP_W = $clog2(MONEY_W + 1);

   logic              busy;
   logic [PRICE_W-1:0] rem;
   logic [PRICE_W-1:0] dsr;
   logic [STEP_W-1:0]  steps_left;

   // The quotient register doubles as the dividend shift register: its MSB is
   // the next dividend bit, and quotient bits enter at the LSB.
   logic [PRICE_W:0]   trial;
   logic               fits;
   logic [PRICE_W-1:0] rem_next;

   always_comb begin
      trial    = {rem, quotient[MONEY_W-1]};
      fits     = (trial >= {1'b0, dsr});
      rem_next = fits ? PRICE_W'(trial - {1'b0, dsr}) : trial[PRICE_W-1:0];
   end

   assign ready = !busy && !done;

   always_ff @(posedge clock) begin
      if (reset) begin
         busy       <= 1'b0;
         done       <= 1'b0;
         quotient   <= '0;
         rem        <= '0;
         dsr        <= '0;
         steps_left <= '0;
      end else begin
         done <= 1'b0;
         if (start && ready) begin
            busy       <= 1'b1;
            quotient   <= dividend;
            rem        <= '0;
            dsr        <= divisor;
            steps_left <= STEP_W'(MONEY_W);
         end else if (busy) begin
            quotient   <= {quotient[MONEY_W-2:0], fits};
            rem        <= rem_next;
            steps_left <= steps_left - STEP_W'(1);
            if (steps_left == STEP_W'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/purchase_controller.sv
// -----------------------------------------------------------------------------
// purchase_controller
// Purchase engine between the customer front-end and the cash, store and log
// handlers. Takes one request per handshake, reads the catalogue, checks stock
// and budget, then either sells (debit -> credit -> stock strobes) or rejects
// with an error code and the maximum affordable count.
//
// Optional build macro: PURCHASE_PARTIAL_FILL_EN
//   defined   : on NO_FUNDS_PARTIAL / NO_STOCK, sell min(max_buyable, stock)
//               when non-zero; the original error code is still reported.
//   undefined : every error rejects without debit, credit or stock strobes.
//
// Ports:
//   clock, reset               rising-edge clock, synchronous active-high reset
//   req_valid / req_ready      request handshake (ready only in IDLE)
//   item_code/item_count/budget request fields, sampled on accept
//   cat_rd_en / cat_rd_addr    catalogue read; cat_price/cat_stock one cycle later
//   debit_valid, credit_valid  cash strobes, both carrying amount
//   stock_dec_*                store decrement strobe, code and count
//   log_valid/log_status/log_price  log record strobe (code/count on stock_dec_*)
//   resp_valid, dp, err_code, max_buyable  completion pulse and result
// -----------------------------------------------------------------------------
module purchase_controller
   import purchase_pkg::*;
#(
   parameter int N_ITEMS = 5,
   parameter int CODE_W  = 3,
   parameter int CNT_W   = 4,
   parameter int PRICE_W = 4,
   parameter int MONEY_W = 8
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [CODE_W-1:0]  item_code,
   input  logic [CNT_W-1:0]   item_count,
   input  logic [MONEY_W-1:0] budget,
   output logic               cat_rd_en,
   output logic [CODE_W-1:0]  cat_rd_addr,
   input  logic [PRICE_W-1:0] cat_price,
   input  logic [CNT_W-1:0]   cat_stock,
   output logic               debit_valid,
   output logic               credit_valid,
   output logic [MONEY_W-1:0] amount,
   output logic               stock_dec_valid,
   output logic [CODE_W-1:0]  stock_dec_code,
   output logic [CNT_W-1:0]   stock_dec_count,
   output logic               log_valid,
   output logic               log_status,
   output logic [PRICE_W-1:0] log_price,
   output logic               resp_valid,
   output logic               dp,
   output logic [2:0]         err_code,
   output logic [MONEY_W-1:0] max_buyable
);

   state_t             state;
   logic [CODE_W-1:0]  code_reg;
   logic [CNT_W-1:0]   count_reg;
   logic [MONEY_W-1:0] budget_reg;
   logic [PRICE_W-1:0] price_reg;
   logic [CNT_W-1:0]   sale_count_reg;
   logic               div_start_reg;

   logic               div_ready;
   logic               div_done;
   logic [MONEY_W-1:0] div_q;

   // Basket total: product of the two narrow fields cannot overflow.
   logic [CNT_W+PRICE_W-1:0] check_total;
   logic [MONEY_W-1:0]       check_amount;

   always_comb begin
      check_total  = {{PRICE_W{1'b0}}, count_reg} * {{CNT_W{1'b0}}, cat_price};
      check_amount = MONEY_W'(check_total);
   end

`ifdef PURCHASE_PARTIAL_FILL_EN
   logic [CNT_W-1:0]         stock_reg;
   logic [CNT_W-1:0]         fill_n;
   logic [CNT_W+PRICE_W-1:0] fill_total;

   // Largest sellable quantity: what the budget covers, capped by stock.
   always_comb begin
      fill_n     = (div_q < MONEY_W'(stock_reg)) ? div_q[CNT_W-1:0] : stock_reg;
      fill_total = {{PRICE_W{1'b0}}, fill_n} * {{CNT_W{1'b0}}, price_reg};
   end
`endif

   purchase_divider #(
      .MONEY_W (MONEY_W),
      .PRICE_W (PRICE_W)
   ) u_divider (
      .clock    (clock),
      .reset    (reset),
      .start    (div_start_reg && div_ready),
      .dividend (budget_reg),
      .divisor  (price_reg),
      .ready    (div_ready),
      .done     (div_done),
      .quotient (div_q)
   );

   // All outputs are registered and set on the edge entering the state that
   // owns them, so each strobe is high for exactly the cycle of its state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state           <= S_IDLE;
         req_ready       <= 1'b1;
         code_reg        <= '0;
         count_reg       <= '0;
         budget_reg      <= '0;
         price_reg       <= '0;
         sale_count_reg  <= '0;
         div_start_reg   <= 1'b0;
         cat_rd_en       <= 1'b0;
         cat_rd_addr     <= '0;
         debit_valid     <= 1'b0;
         credit_valid    <= 1'b0;
         amount          <= '0;
         stock_dec_valid <= 1'b0;
         stock_dec_code  <= '0;
         stock_dec_count <= '0;
         log_valid       <= 1'b0;
         log_status      <= LOG_REJECTED;
         log_price       <= '0;
         resp_valid      <= 1'b0;
         dp              <= 1'b0;
         err_code        <= ERR_OK;
         max_buyable     <= '0;
`ifdef PURCHASE_PARTIAL_FILL_EN
         stock_reg       <= '0;
`endif
      end else begin
         cat_rd_en       <= 1'b0;
         debit_valid     <= 1'b0;
         credit_valid    <= 1'b0;
         stock_dec_valid <= 1'b0;
         log_valid       <= 1'b0;
         resp_valid      <= 1'b0;
         div_start_reg   <= 1'b0;

         case (state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  code_reg    <= item_code;
                  count_reg   <= item_count;
                  budget_reg  <= budget;
                  req_ready   <= 1'b0;
                  dp          <= 1'b0;
                  err_code    <= ERR_OK;
                  max_buyable <= '0;
                  amount      <= '0;
                  // Code check wins over the zero-count check.
                  if (int'(item_code) >= N_ITEMS) begin
                     err_code   <= ERR_BAD_CODE;
                     log_valid  <= 1'b1;
                     log_status <= LOG_REJECTED;
                     log_price  <= '0;
                     state      <= S_LOG;
                  end else if (item_count == '0) begin
                     err_code   <= ERR_ZERO_COUNT;
                     log_valid  <= 1'b1;
                     log_status <= LOG_REJECTED;
                     log_price  <= '0;
                     state      <= S_LOG;
                  end else begin
                     cat_rd_en   <= 1'b1;
                     cat_rd_addr <= item_code;
                     state       <= S_LOOKUP;
                  end
               end
            end

            S_LOOKUP: state <= S_CHECK;

            S_CHECK: begin
               price_reg      <= cat_price;
               amount         <= check_amount;
               sale_count_reg <= count_reg;
`ifdef PURCHASE_PARTIAL_FILL_EN
               stock_reg      <= cat_stock;
`endif
               if (cat_stock < count_reg) begin
                  err_code <= ERR_NO_STOCK;
`ifdef PURCHASE_PARTIAL_FILL_EN
                  // Need the affordable count to size a partial sale.
                  div_start_reg <= 1'b1;
                  state         <= S_DIV;
`else
                  log_valid  <= 1'b1;
                  log_status <= LOG_REJECTED;
                  log_price  <= cat_price;
                  state      <= S_LOG;
`endif
               end else if (check_amount > budget_reg) begin
                  div_start_reg <= 1'b1;
                  state         <= S_DIV;
               end else begin
                  debit_valid <= 1'b1;
                  state       <= S_DEBIT;
               end
            end

            S_DIV: begin
               if (div_done) begin
                  // err_code already holds NO_STOCK when that path got here.
                  if (err_code != ERR_NO_STOCK) begin
                     max_buyable <= div_q;
                     err_code    <= (div_q == '0) ? ERR_NO_FUNDS_ANY : ERR_NO_FUNDS_PARTIAL;
                  end
`ifdef PURCHASE_PARTIAL_FILL_EN
                  if (fill_n != '0) begin
                     amount         <= MONEY_W'(fill_total);
                     sale_count_reg <= fill_n;
                     debit_valid    <= 1'b1;
                     state          <= S_DEBIT;
                  end else
`endif
                  begin
                     log_valid  <= 1'b1;
                     log_status <= LOG_REJECTED;
                     log_price  <= price_reg;
                     state      <= S_LOG;
                  end
               end
            end

            S_DEBIT: begin
               credit_valid <= 1'b1;
               state        <= S_CREDIT;
            end

            S_CREDIT: begin
               stock_dec_valid <= 1'b1;
               stock_dec_code  <= code_reg;
               stock_dec_count <= sale_count_reg;
               state           <= S_STOCK;
            end

            S_STOCK: begin
               log_valid  <= 1'b1;
               log_status <= LOG_SOLD;
               log_price  <= price_reg;
               state      <= S_LOG;
            end

            S_LOG: begin
               resp_valid <= 1'b1;
               dp         <= (err_code != ERR_OK);
               state      <= S_RESP;
            end

            S_RESP: begin
               req_ready <= 1'b1;
               state     <= S_IDLE;
            end

            default: begin
               req_ready <= 1'b1;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
